shift_seq16: RTL and testbench
==============================

SHIFT_SEQ16 -- requirements
Module: shift_seq16

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits and shift amount at 4 bits.
REQ-002 The block SHALL use one clock, clk; reset is synchronous and active-high, rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  request present on in_val/in_dir/in_amt/in_mode.
REQ-006 in_ready  output  1  block can accept a request (high only in IDLE).
REQ-007 in_val  input  16  operand.
REQ-008 in_dir  input  1  direction: 1 = left (toward MSB), 0 = right.
REQ-009 in_amt  input  4  shift amount, 0..15 positions.
REQ-010 in_mode  input  2  shift-in source: 00 logical, 01 arithmetic, 10 rotate, 11 fill-ones.
REQ-011 out_valid  output  1  result present on out_res/out_last.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_res  output  16  shifted result.
REQ-014 out_last  output  1  bit shifted out by the final single-position shift.

Function
REQ-015 The block SHALL be an FSM with states IDLE, SHIFT and DONE, performing an N-position shift as N successive one-position shifts of an internal 16-bit register, one per clock.
REQ-016 in_ready SHALL equal (state == IDLE); a handshake occurs when in_valid and in_ready are both high at a rising edge.
REQ-017 On handshake the block SHALL capture in_val, in_dir, in_mode and in_amt, clear out_last, and go to SHIFT if in_amt != 0, else to DONE.
REQ-018 In SHIFT, each cycle SHALL shift the register one position in the captured direction, load out_last with the bit leaving the register, and decrement the remaining count; when the count reaches 0 after a shift, the next state SHALL be DONE.
REQ-019 Shift-in bit: logical = 0; arithmetic = current MSB for right shifts and 0 for left shifts; rotate = the bit leaving the register in the same cycle; fill-ones = 1.
REQ-020 Latency: out_valid SHALL first be high in the cycle in_amt+1 cycles after the handshake cycle (1 cycle when in_amt = 0).
REQ-021 When in_amt = 0: out_res SHALL equal in_val and out_last SHALL be 0.
REQ-022 out_valid SHALL equal (state == DONE); out_res and out_last SHALL be registered and held stable while out_valid is high.
REQ-023 In DONE, when out_ready is high at a rising edge, the next state SHALL be IDLE; when out_ready is low, DONE SHALL be held indefinitely.
REQ-024 There SHALL be no same-cycle accept on output retirement; in_ready rises in the cycle after the out_valid/out_ready handshake.
REQ-025 in_valid and the request inputs SHALL be ignored in SHIFT and DONE; captured operands SHALL NOT change mid-operation.
REQ-026 out_ready SHALL be ignored outside DONE.

Reset
REQ-027 While rst is high at a rising edge: state = IDLE, out_valid = 0, out_res = 16'h0000, out_last = 0, and remaining count = 0; in_ready SHALL be 1 in the following cycle.
REQ-028 Reset asserted in SHIFT or DONE SHALL discard the in-flight operation with no output handshake.
REQ-029 A request presented with in_valid high during the rst cycle SHALL NOT be accepted.

Verification
REQ-030 in_val=16'h8001, left, amt=1, logical -> out_res=16'h0002, out_last=1, out_valid 2 cycles after handshake.
REQ-031 in_val=16'h8000, right, amt=4, arithmetic -> out_res=16'hF800, out_last=0, latency 5 cycles; also in_val=16'h0000, right, amt=3, fill-ones -> out_res=16'hE000.
REQ-032 in_val=16'h1234, left, amt=4, rotate -> out_res=16'h2341, out_last=1; the same request with amt=15 right-rotate -> out_res=16'h2468.
REQ-033 in_val=16'hBEEF, amt=0, any mode -> out_res=16'hBEEF, out_last=0, out_valid 1 cycle after handshake.
REQ-034 Hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new data -> out_res/out_last stable, in_ready=0, no new capture; release -> in_ready=1 the next cycle.
REQ-035 Assert rst mid-SHIFT (amt=10, cycle 3) -> next cycle out_valid=0, out_res=16'h0000, in_ready=1; a subsequent request completes normally.

Source files
------------

// File: rtl/shift_seq16.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq16
// Description : Sequential 16-bit shifter. A request (operand, direction,
//               amount, shift-in mode) is accepted in IDLE and carried out as
//               N single-position shifts, one per clock. The result is held in
//               DONE until the consumer accepts it.
// Ports       : clk, rst           - clock / synchronous active-high reset
//               in_valid/in_ready  - request handshake (ready only in IDLE)
//               in_val[15:0]       - operand
//               in_dir             - 1 = left (toward MSB), 0 = right
//               in_amt[3:0]        - shift amount 0..15
//               in_mode[1:0]       - 00 logical, 01 arith, 10 rotate, 11 ones
//               out_valid/out_ready- result handshake (valid only in DONE)
//               out_res[15:0]      - shifted result
//               out_last           - bit shifted out by the final step
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_val,
  input  logic        in_dir,
  input  logic [3:0]  in_amt,
  input  logic [1:0]  in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_res,
  output logic        out_last
);

  localparam logic [1:0] c_MODE_LOGIC = 2'b00;
  localparam logic [1:0] c_MODE_ARITH = 2'b01;
  localparam logic [1:0] c_MODE_ROT   = 2'b10;
  localparam logic [1:0] c_MODE_ONES  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_sh;
  logic        r_dir;
  logic [1:0]  r_mode;
  logic [3:0]  r_cnt;
  logic        r_last;

  logic        w_leave;
  logic        w_shin;
  logic [15:0] w_sh_nxt;

  // Bit leaving the register on this step depends only on direction.
  assign w_leave = r_dir ? r_sh[15] : r_sh[0];

  // Shift-in source. Arithmetic only replicates the sign on right shifts;
  // rotate feeds the leaving bit straight back into the vacated end.
  always_comb begin
    w_shin = 1'b0;
    case (r_mode)
      c_MODE_LOGIC: w_shin = 1'b0;
      c_MODE_ARITH: w_shin = r_dir ? 1'b0 : r_sh[15];
      c_MODE_ROT:   w_shin = w_leave;
      c_MODE_ONES:  w_shin = 1'b1;
      default:      w_shin = 1'b0;
    endcase
  end

  assign w_sh_nxt = r_dir ? {r_sh[14:0], w_shin} : {w_shin, r_sh[15:1]};

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = (in_amt != 4'd0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        // Count still holds the pre-decrement value: 1 means last step.
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sh    <= 16'h0000;
      r_dir   <= 1'b0;
      r_mode  <= 2'b00;
      r_cnt   <= 4'd0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sh   <= in_val;
            r_dir  <= in_dir;
            r_mode <= in_mode;
            r_cnt  <= in_amt;
            r_last <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_sh   <= w_sh_nxt;
          r_last <= w_leave;
          r_cnt  <= r_cnt - 4'd1;
        end
        default: begin
          // DONE holds the result stable; nothing updates.
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_res   = r_sh;
  assign out_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq16.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq16
// Description : Self-checking bench for shift_seq16. Table of request vectors
//               with expected results; expectations are queued on request
//               acceptance and popped when the result appears. Hand-written
//               sequences cover reset, output back-pressure and mid-shift
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_val;
  logic        in_dir;
  logic [3:0]  in_amt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        out_last;

  shift_seq16 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_val   (in_val),
    .in_dir   (in_dir),
    .in_amt   (in_amt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic        dir;
    logic [3:0]  amt;
    logic [1:0]  mode;
    logic [15:0] res;
    logic        last;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        last;
    int          lat;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-word reference: result and the last bit to leave the register.
  function automatic logic [16:0] model(input logic [15:0] v, input logic d,
                                        input logic [3:0] n, input logic [1:0] m);
    logic [15:0] r;
    logic [15:0] ones;
    logic        l;
    int          k;
    k    = int'(n);
    ones = 16'hFFFF;
    r    = v;
    l    = 1'b0;
    if (k != 0) begin
      if (d) begin
        l = v[16-k];
        case (m)
          2'b10:   r = (v << k) | (v >> (16 - k));
          2'b11:   r = (v << k) | ~(ones << k);
          default: r = v << k;
        endcase
      end else begin
        l = v[k-1];
        case (m)
          2'b00:   r = v >> k;
          2'b01:   r = 16'($signed(v) >>> k);
          2'b10:   r = (v >> k) | (v << (16 - k));
          default: r = (v >> k) | ~(ones >> k);
        endcase
      end
    end
    return {r, l};
  endfunction

  function automatic vec_t mk(input logic [15:0] v, input logic d,
                              input logic [3:0] n, input logic [1:0] m);
    vec_t t;
    logic [16:0] x;
    x      = model(v, d, n, m);
    t.val  = v;
    t.dir  = d;
    t.amt  = n;
    t.mode = m;
    t.res  = x[16:1];
    t.last = x[0];
    return t;
  endfunction

  task automatic wait_ready();
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_req(input vec_t t);
    int   cyc;
    exp_t e;
    wait_ready();
    in_val   = t.val;
    in_dir   = t.dir;
    in_amt   = t.amt;
    in_mode  = t.mode;
    in_valid = 1'b1;
    tick();
    e.res  = t.res;
    e.last = t.last;
    e.lat  = int'(t.amt) + 1;
    sb.push_back(e);
    // Scramble request inputs: captured operands must not follow them.
    in_valid = 1'b0;
    in_val   = 16'($urandom);
    in_dir   = 1'($urandom);
    in_amt   = 4'($urandom);
    in_mode  = 2'($urandom);
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("latency", 32'(cyc), 32'(e.lat));
      check("out_res", {16'd0, out_res}, {16'd0, e.res});
      check("out_last", {31'd0, out_last}, {31'd0, e.last});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_retired", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_retire", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t t;
    int   cyc;

    // Directed values; expectations written out by hand.
    t = '{16'h8001, 1'b1, 4'd1,  2'b00, 16'h0002, 1'b1}; tbl.push_back(t);
    t = '{16'h8000, 1'b0, 4'd4,  2'b01, 16'hF800, 1'b0}; tbl.push_back(t);
    t = '{16'h0000, 1'b0, 4'd3,  2'b11, 16'hE000, 1'b0}; tbl.push_back(t);
    t = '{16'h1234, 1'b1, 4'd4,  2'b10, 16'h2341, 1'b1}; tbl.push_back(t);
    t = '{16'h1234, 1'b0, 4'd15, 2'b10, 16'h2468, 1'b0}; tbl.push_back(t);
    t = '{16'hBEEF, 1'b0, 4'd0,  2'b01, 16'hBEEF, 1'b0}; tbl.push_back(t);
    t = '{16'hBEEF, 1'b1, 4'd0,  2'b11, 16'hBEEF, 1'b0}; tbl.push_back(t);
    t = '{16'h8001, 1'b1, 4'd3,  2'b01, 16'h0008, 1'b0}; tbl.push_back(t);
    // Every mode/direction at the maximum amount, then random requests.
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 4; m++)
        tbl.push_back(mk(16'hA5C3, 1'(d), 4'd15, 2'(m)));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(16'($urandom), 1'($urandom), 4'($urandom), 2'($urandom)));

    // Reset with a request present: it must not be taken.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_val    = 16'h5555;
    in_dir    = 1'b1;
    in_amt    = 4'd0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_res", {16'd0, out_res}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    tick();
    check("rst_no_capture", {31'd0, out_valid}, 32'd0);

    foreach (tbl[i]) run_req(tbl[i]);

    // Back-pressure in DONE while a new request is offered.
    wait_ready();
    in_val = 16'h1234; in_dir = 1'b1; in_amt = 4'd4; in_mode = 2'b10;
    in_valid = 1'b1;
    tick();
    in_val = 16'hFFFF; in_amt = 4'd0; in_mode = 2'b00;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("hold_latency", 32'(cyc), 32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_res", {16'd0, out_res}, 32'h2341);
      check("hold_last", {31'd0, out_last}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("release_no_capture", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a 10-step shift.
    wait_ready();
    in_val = 16'h00FF; in_dir = 1'b1; in_amt = 4'd10; in_mode = 2'b11;
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_res", {16'd0, out_res}, 32'd0);
    check("midrst_out_last", {31'd0, out_last}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    run_req(mk(16'h00FF, 1'b1, 4'd10, 2'b11));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
